// File: rtl/x86_fetch_unit.sv
`default_nettype none
// =============================================================================
// Module   : x86_fetch_unit
// Brief    : Byte-queue instruction fetcher with i386-subset length decode and
//            valid/ready hand-off; owns EIP. FETCH_PERF_EN adds perf_stall.
// Revision : 1.0
// =============================================================================
module x86_fetch_unit #(
   parameter logic [31:0] RESET_EIP = 32'h00000027,
   parameter int unsigned QDEPTH    = 8
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_data,
   input  logic        redirect,
   input  logic [31:0] redirect_eip,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [47:0] inst_bytes,
   output logic [2:0]  inst_len,
   output logic [31:0] inst_eip,
   output logic        ill_op
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0] perf_stall
`endif
);

   localparam int unsigned     c_AW       = $clog2(QDEPTH);
   localparam int unsigned     c_CW       = c_AW + 1;
   localparam logic [c_CW-1:0] c_FILL_MAX = c_CW'(QDEPTH - 4);

   typedef enum logic [0:0] {
      S_RUN  = 1'b0,
      S_HALT = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [7:0]      r_q [QDEPTH];
   logic [c_AW-1:0] r_rd;
   logic [c_AW-1:0] r_wr;
   logic [c_CW-1:0] r_count;
   logic [31:0]     r_fetch_ptr;
   logic [31:0]     r_eip;

   logic [7:0]      w_b [5];
   logic [2:0]      w_len;
   logic            w_dec_ok;
   logic            w_dec_ill;
   logic            w_pop;
   logic            w_push;
   logic [c_CW-1:0] w_pop_len;
   logic [c_CW-1:0] w_count_after_pop;

   always_comb begin
      for (int i = 0; i < 5; i++) begin
         w_b[i] = r_q[r_rd + c_AW'(i)];
      end
   end

   // Modrm-form opcodes stay undecided until their second byte is queued.
   always_comb begin
      w_len     = 3'd0;
      w_dec_ok  = 1'b0;
      w_dec_ill = 1'b0;
      if (r_count != '0) begin
         case (w_b[0])
            8'h55, 8'h5D, 8'h50, 8'h53, 8'hC3, 8'hC9: begin
               w_len    = 3'd1;
               w_dec_ok = 1'b1;
            end
            8'h6A, 8'h75, 8'hEB: begin
               w_len    = 3'd2;
               w_dec_ok = 1'b1;
            end
            8'hB8, 8'hE8: begin
               w_len    = 3'd5;
               w_dec_ok = 1'b1;
            end
            8'h89, 8'h8B, 8'h01, 8'h83: begin
               if (r_count >= c_CW'(2)) begin
                  case (w_b[1][7:6])
                     2'b11: begin
                        w_len    = (w_b[0] == 8'h83) ? 3'd3 : 3'd2;
                        w_dec_ok = 1'b1;
                     end
                     2'b01: begin
                        w_len    = (w_b[0] == 8'h83) ? 3'd4 : 3'd3;
                        w_dec_ok = 1'b1;
                     end
                     default: w_dec_ill = 1'b1;
                  endcase
               end
            end
            default: w_dec_ill = 1'b1;
         endcase
      end
   end

   assign inst_valid = (r_state == S_RUN) && !redirect && w_dec_ok &&
                       (r_count >= c_CW'(w_len));
   assign inst_len   = w_dec_ok ? w_len : 3'd0;
   assign inst_eip   = r_eip;
   assign ill_op     = (r_state == S_HALT) || w_dec_ill;
   assign mem_addr   = r_fetch_ptr;

   always_comb begin
      inst_bytes = '0;
      for (int i = 0; i < 5; i++) begin
         if ((c_CW'(i) < r_count) && (3'(i) < inst_len)) begin
            inst_bytes[47-8*i -: 8] = w_b[i];
         end
      end
   end

   // Refill decision uses the occupancy left after this cycle's pop.
   assign w_pop             = inst_valid && inst_ready;
   assign w_pop_len         = w_pop ? c_CW'(w_len) : '0;
   assign w_count_after_pop = r_count - w_pop_len;
   assign w_push            = (r_state == S_RUN) && !redirect &&
                              (w_count_after_pop <= c_FILL_MAX);

   always_comb begin
      w_state_nxt = r_state;
      if (redirect) begin
         w_state_nxt = S_RUN;
      end else if ((r_state == S_RUN) && w_dec_ill) begin
         w_state_nxt = S_HALT;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= S_RUN;
         r_rd        <= '0;
         r_wr        <= '0;
         r_count     <= '0;
         r_fetch_ptr <= RESET_EIP;
         r_eip       <= RESET_EIP;
      end else begin
         r_state <= w_state_nxt;
         if (redirect) begin
            r_rd        <= '0;
            r_wr        <= '0;
            r_count     <= '0;
            r_fetch_ptr <= redirect_eip;
            r_eip       <= redirect_eip;
         end else begin
            if (w_pop) begin
               r_rd  <= r_rd + c_AW'(w_len);
               r_eip <= r_eip + 32'(w_len);
            end
            if (w_push) begin
               r_wr        <= r_wr + c_AW'(4);
               r_fetch_ptr <= r_fetch_ptr + 32'd4;
            end
            r_count <= w_count_after_pop + (w_push ? c_CW'(4) : '0);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         for (int i = 0; i < 4; i++) begin
            r_q[r_wr + c_AW'(i)] <= mem_data[31-8*i -: 8];
         end
      end
   end

`ifdef FETCH_PERF_EN
   logic [15:0] r_perf_stall;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_perf_stall <= '0;
      end else if (inst_ready && !inst_valid && (r_state == S_RUN) &&
                   (r_perf_stall != 16'hFFFF)) begin
         r_perf_stall <= r_perf_stall + 16'd1;
      end
   end

   assign perf_stall = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_x86_fetch_unit.sv
`default_nettype none
// =============================================================================
// Module   : tb_x86_fetch_unit
// Brief    : Self-checking bench for x86_fetch_unit (stream scoreboard, decode
//            table, reset/fill, redirect and illegal-opcode sequences).
// Revision : 1.0
// =============================================================================
module tb_x86_fetch_unit;

   logic        clk;
   logic        reset;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic        redirect;
   logic [31:0] redirect_eip;
   logic        inst_valid;
   logic        inst_ready;
   logic [47:0] inst_bytes;
   logic [2:0]  inst_len;
   logic [31:0] inst_eip;
   logic        ill_op;
`ifdef FETCH_PERF_EN
   logic [15:0] perf_stall;
`endif

   x86_fetch_unit dut (
      .clk          (clk),
      .reset        (reset),
      .mem_addr     (mem_addr),
      .mem_data     (mem_data),
      .redirect     (redirect),
      .redirect_eip (redirect_eip),
      .inst_valid   (inst_valid),
      .inst_ready   (inst_ready),
      .inst_bytes   (inst_bytes),
      .inst_len     (inst_len),
      .inst_eip     (inst_eip),
      .ill_op       (ill_op)
`ifdef FETCH_PERF_EN
      ,
      .perf_stall   (perf_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] mem [256];
   logic [7:0] w_ma;
   assign w_ma = mem_addr[7:0];
   always_comb mem_data = {mem[w_ma], mem[w_ma + 8'd1], mem[w_ma + 8'd2], mem[w_ma + 8'd3]};

   typedef struct {
      logic [31:0] eip;
      logic [2:0]  len;
      logic [47:0] bytes;
   } inst_t;

   typedef struct {
      logic [7:0] h;
      logic [7:0] m;
      logic [2:0] len;
      logic       ill;
   } dec_t;

   inst_t stream_tbl [8];
   dec_t  dec_tbl [21];
   inst_t sb [$];

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard side: every accepted instruction must match the queue head.
   initial begin
      inst_t e;
      forever begin
         @(negedge clk);
         #2;
         if (reset && inst_valid && inst_ready) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL sb_unexpected: got eip %0h len %0d, expected no transfer", inst_eip, inst_len);
            end else begin
               e = sb.pop_front();
               chk("sb_eip", 64'(inst_eip), 64'(e.eip));
               chk("sb_len", 64'(inst_len), 64'(e.len));
               chk("sb_bytes", 64'(inst_bytes), 64'(e.bytes));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      logic [47:0] eb;
      logic [7:0]  k;

      stream_tbl[0] = '{32'h27, 3'd1, 48'h550000000000};
      stream_tbl[1] = '{32'h28, 3'd2, 48'h89E500000000};
      stream_tbl[2] = '{32'h2A, 3'd3, 48'h83EC08000000};
      stream_tbl[3] = '{32'h2D, 3'd3, 48'h83EC0C000000};
      stream_tbl[4] = '{32'h30, 3'd2, 48'h6A0300000000};
      stream_tbl[5] = '{32'h32, 3'd5, 48'hE8C9FFFFFF00};
      stream_tbl[6] = '{32'h37, 3'd1, 48'hC90000000000};
      stream_tbl[7] = '{32'h38, 3'd1, 48'hC30000000000};

      dec_tbl[0]  = '{8'h55, 8'h00, 3'd1, 1'b0};
      dec_tbl[1]  = '{8'h5D, 8'h00, 3'd1, 1'b0};
      dec_tbl[2]  = '{8'h50, 8'h00, 3'd1, 1'b0};
      dec_tbl[3]  = '{8'h53, 8'h00, 3'd1, 1'b0};
      dec_tbl[4]  = '{8'hC3, 8'h00, 3'd1, 1'b0};
      dec_tbl[5]  = '{8'hC9, 8'h00, 3'd1, 1'b0};
      dec_tbl[6]  = '{8'h6A, 8'h05, 3'd2, 1'b0};
      dec_tbl[7]  = '{8'h75, 8'hFE, 3'd2, 1'b0};
      dec_tbl[8]  = '{8'hEB, 8'h10, 3'd2, 1'b0};
      dec_tbl[9]  = '{8'hB8, 8'h01, 3'd5, 1'b0};
      dec_tbl[10] = '{8'hE8, 8'hC9, 3'd5, 1'b0};
      dec_tbl[11] = '{8'h89, 8'hC0, 3'd2, 1'b0};
      dec_tbl[12] = '{8'h89, 8'h45, 3'd3, 1'b0};
      dec_tbl[13] = '{8'h8B, 8'hEC, 3'd2, 1'b0};
      dec_tbl[14] = '{8'h01, 8'h45, 3'd3, 1'b0};
      dec_tbl[15] = '{8'h83, 8'hEC, 3'd3, 1'b0};
      dec_tbl[16] = '{8'h83, 8'h45, 3'd4, 1'b0};
      dec_tbl[17] = '{8'h89, 8'h05, 3'd0, 1'b1};
      dec_tbl[18] = '{8'h83, 8'h85, 3'd0, 1'b1};
      dec_tbl[19] = '{8'h0F, 8'h0B, 3'd0, 1'b1};
      dec_tbl[20] = '{8'h90, 8'h00, 3'd0, 1'b1};

      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      {mem[8'h27], mem[8'h28], mem[8'h29], mem[8'h2A], mem[8'h2B], mem[8'h2C]} = 48'h5589E583EC08;
      {mem[8'h2D], mem[8'h2E], mem[8'h2F], mem[8'h30], mem[8'h31], mem[8'h32]} = 48'h83EC0C6A03E8;
      {mem[8'h33], mem[8'h34], mem[8'h35], mem[8'h36], mem[8'h37], mem[8'h38]} = 48'hC9FFFFFFC9C3;
      {mem[8'h00], mem[8'h01], mem[8'h02], mem[8'h03]} = 32'h5589E5C3;
      {mem[8'h80], mem[8'h81]} = 16'h0F0B;

      reset        = 1'b0;
      redirect     = 1'b0;
      redirect_eip = 32'h0;
      inst_ready   = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_valid", 64'(inst_valid), 64'd0);
      chk("rst_len", 64'(inst_len), 64'd0);
      chk("rst_bytes", 64'(inst_bytes), 64'd0);
      chk("rst_ill", 64'(ill_op), 64'd0);
      chk("rst_addr", 64'(mem_addr), 64'h27);
      chk("rst_eip", 64'(inst_eip), 64'h27);

      // Fill latency and back-pressure with ready low
      reset = 1'b1;
      @(negedge clk);
      chk("lat_valid", 64'(inst_valid), 64'd1);
      chk("lat_addr", 64'(mem_addr), 64'h2B);
      repeat (9) @(negedge clk);
      chk("hold_addr", 64'(mem_addr), 64'h2F);
      chk("hold_eip", 64'(inst_eip), 64'h27);
      chk("hold_len", 64'(inst_len), 64'd1);
      chk("hold_bytes", 64'(inst_bytes), 64'h550000000000);

      // Streaming from reset with ready high
      reset = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 8; i++) sb.push_back(stream_tbl[i]);
      reset      = 1'b1;
      inst_ready = 1'b1;
`ifdef FETCH_PERF_EN
      repeat (3) @(negedge clk);
      chk("perf_stall", 64'(perf_stall), 64'd1);
`endif
      for (int c = 0; c < 300 && sb.size() != 0; c++) @(negedge clk);
      chk("stream_drain", 64'(sb.size()), 64'd0);
      repeat (3) @(negedge clk);
      chk("stream_halt_ill", 64'(ill_op), 64'd1);
      chk("stream_halt_valid", 64'(inst_valid), 64'd0);
      chk("stream_halt_eip", 64'(inst_eip), 64'h39);

      // Redirect during a valid handshake
      inst_ready = 1'b0;
      reset      = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rd_pre_valid", 64'(inst_valid), 64'd1);
      inst_ready   = 1'b1;
      redirect     = 1'b1;
      redirect_eip = 32'h0;
      #1;
      chk("rd_forced_valid", 64'(inst_valid), 64'd0);
      @(negedge clk);
      redirect   = 1'b0;
      inst_ready = 1'b0;
      #1;
      chk("rd_next_valid", 64'(inst_valid), 64'd0);
      chk("rd_next_eip", 64'(inst_eip), 64'h0);
      chk("rd_next_addr", 64'(mem_addr), 64'h0);
      @(negedge clk);
      chk("rd_fill_valid", 64'(inst_valid), 64'd1);
      chk("rd_fill_eip", 64'(inst_eip), 64'h0);
      chk("rd_fill_byte", 64'(inst_bytes[47:40]), 64'h55);

      // Illegal head holds HALT until redirected
      redirect     = 1'b1;
      redirect_eip = 32'h80;
      inst_ready   = 1'b1;
      @(negedge clk);
      redirect = 1'b0;
      for (int c = 0; c < 22; c++) begin
         @(negedge clk);
         if (c >= 1) begin
            chk("ill_hold_ill", 64'(ill_op), 64'd1);
            chk("ill_hold_valid", 64'(inst_valid), 64'd0);
         end
      end
      chk("ill_hold_eip", 64'(inst_eip), 64'h80);
      redirect     = 1'b1;
      redirect_eip = 32'h27;
      inst_ready   = 1'b0;
      @(negedge clk);
      redirect = 1'b0;
      #1;
      chk("ill_clear", 64'(ill_op), 64'd0);
      @(negedge clk);
      chk("ill_rec_valid", 64'(inst_valid), 64'd1);
      chk("ill_rec_eip", 64'(inst_eip), 64'h27);
      chk("ill_rec_bytes", 64'(inst_bytes), 64'h550000000000);

      // Length-decode table, each head placed at 0xC0
      {mem[8'hC2], mem[8'hC3], mem[8'hC4], mem[8'hC5], mem[8'hC6], mem[8'hC7]} = 48'h112233445566;
      for (int i = 0; i < 21; i++) begin
         mem[8'hC0] = dec_tbl[i].h;
         mem[8'hC1] = dec_tbl[i].m;
         eb = '0;
         for (int j = 0; j < 5; j++) begin
            if (j < int'(dec_tbl[i].len)) begin
               k = 8'hC0 + 8'(j);
               eb[47-8*j -: 8] = mem[k];
            end
         end
         redirect     = 1'b1;
         redirect_eip = 32'hC0;
         @(negedge clk);
         redirect = 1'b0;
         repeat (2) @(negedge clk);
         chk("dec_ill", 64'(ill_op), 64'(dec_tbl[i].ill));
         chk("dec_valid", 64'(inst_valid), 64'(!dec_tbl[i].ill));
         if (!dec_tbl[i].ill) begin
            chk("dec_len", 64'(inst_len), 64'(dec_tbl[i].len));
            chk("dec_bytes", 64'(inst_bytes), 64'(eb));
         end
      end

      @(negedge clk);
      chk("sb_final_empty", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
